// File: rtl/twiddle_addr_gen_1024.sv
// Twiddle ROM read sequencer for a 1024-point radix-2 DIF FFT.
// Walks 10 stages x 512 butterflies and issues one ROM read per butterfly.
// Absorbs the ROM's 1-cycle read latency in a 2-entry buffer and presents
// each twiddle on a valid/ready stream.
module twiddle_addr_gen_1024 #(
    parameter int TWIDDLE_WIDTH = 64,
    parameter int ADDR_WIDTH    = 8,
    parameter int LOG2N         = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic                       busy,
    output logic                       done,
    output logic                       rom_en,
    output logic [ADDR_WIDTH:0]        rom_addr,
    input  logic [TWIDDLE_WIDTH-1:0]   rom_twiddle,
    output logic                       tw_valid,
    input  logic                       tw_ready,
    output logic [TWIDDLE_WIDTH/2-1:0] tw_real,
    output logic [TWIDDLE_WIDTH/2-1:0] tw_imag,
    output logic [3:0]                 tw_stage,
    output logic                       tw_last
);

    localparam int                HALF   = TWIDDLE_WIDTH / 2;
    localparam logic [3:0]        LAST_S = 4'(LOG2N - 1);
    localparam logic [ADDR_WIDTH:0] LAST_J = '1;
    localparam logic [ADDR_WIDTH:0] J_ONE  = (ADDR_WIDTH+1)'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Issue counters: stage and butterfly index of the next read.
    logic [3:0]          r_s;
    logic [ADDR_WIDTH:0] r_j;
    logic [ADDR_WIDTH:0] r_addr_hold;

    // Read in flight: its tag travels alongside until the data returns.
    logic       r_inflight;
    logic [3:0] r_inflight_stage;
    logic       r_inflight_last;

    // 2-entry buffer of {data, stage, last}.
    logic [TWIDDLE_WIDTH-1:0] r_fifo_data  [2];
    logic [3:0]               r_fifo_stage [2];
    logic                     r_fifo_last  [2];
    logic                     r_wptr;
    logic                     r_rptr;
    logic [1:0]               r_count;

    logic r_done;

    logic                w_issue;
    logic                w_done_set;
    logic                w_push;
    logic                w_pop;
    logic                w_start_acc;
    logic                w_last_issue;
    logic [1:0]          w_credit;
    logic [ADDR_WIDTH:0] w_addr;

    assign w_start_acc  = (r_state == S_IDLE) && start;
    assign w_last_issue = (r_s == LAST_S) && (r_j == LAST_J);
    // Twiddle stride doubles each stage; bits shifted past the port width wrap
    // the index modulo the ROM depth.
    assign w_addr       = r_j << r_s;
    assign w_push       = r_inflight;
    assign w_pop        = tw_valid && tw_ready;
    assign w_credit     = r_count + {1'b0, r_inflight};

    assign tw_valid = (r_count != 2'd0);
    assign tw_real  = r_fifo_data[r_rptr][TWIDDLE_WIDTH-1:HALF];
    assign tw_imag  = r_fifo_data[r_rptr][HALF-1:0];
    assign tw_stage = r_fifo_stage[r_rptr];
    assign tw_last  = r_fifo_last[r_rptr];

    assign rom_en   = w_issue;
    assign rom_addr = w_issue ? w_addr : r_addr_hold;

    assign done = r_done;
    // busy covers the done cycle so it falls only once the pulse is over.
    assign busy = (r_state != S_IDLE) || r_done;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic, read issue and end-of-sequence detection.
    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_done_set  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A pop in this cycle frees a slot in time for the returning data.
                if ((w_credit < 2'd2) || ((w_credit == 2'd2) && w_pop)) begin
                    w_issue = 1'b1;
                end
                if (w_issue && w_last_issue) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && tw_last) begin
                    w_state_nxt = S_IDLE;
                    w_done_set  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Stage/butterfly counters: cleared on an accepted start, advanced per read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s <= 4'd0;
            r_j <= '0;
        end else if (w_start_acc) begin
            r_s <= 4'd0;
            r_j <= '0;
        end else if (w_issue) begin
            if (r_j == LAST_J) begin
                r_j <= '0;
                r_s <= r_s + 4'd1;
            end else begin
                r_j <= r_j + J_ONE;
            end
        end
    end

    // Hold the last issued address on the ROM port while no read is issued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr_hold <= '0;
        end else if (w_issue) begin
            r_addr_hold <= w_addr;
        end
    end

    // Tag of the read in flight; cleared on reset so stale ROM data is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inflight       <= 1'b0;
            r_inflight_stage <= 4'd0;
            r_inflight_last  <= 1'b0;
        end else begin
            r_inflight       <= w_issue;
            r_inflight_stage <= r_s;
            r_inflight_last  <= w_last_issue;
        end
    end

    // Buffer storage: capture returning ROM data with its tag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i]  <= '0;
                r_fifo_stage[i] <= 4'd0;
                r_fifo_last[i]  <= 1'b0;
            end
        end else if (w_push) begin
            r_fifo_data[r_wptr]  <= rom_twiddle;
            r_fifo_stage[r_wptr] <= r_inflight_stage;
            r_fifo_last[r_wptr]  <= r_inflight_last;
        end
    end

    // Buffer pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wptr <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    // One-cycle done pulse following the final handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_done_set;
        end
    end

endmodule

// File: tb/tb_twiddle_addr_gen_1024.sv
// Bench for twiddle_addr_gen_1024: ROM model, behavioural sequence model,
// per-cycle compare process and scenario-driven stimulus.
module tb_twiddle_addr_gen_1024;

    localparam int N = 5120;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic        rom_en;
    logic [8:0]  rom_addr;
    logic [63:0] rom_twiddle;
    logic        tw_valid;
    logic        tw_ready;
    logic [31:0] tw_real;
    logic [31:0] tw_imag;
    logic [3:0]  tw_stage;
    logic        tw_last;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [8:0] exp_addr  [N];
    int         exp_stage [N];
    bit         exp_last  [N];

    int done_xfers = 0;

    twiddle_addr_gen_1024 #(
        .TWIDDLE_WIDTH(64),
        .ADDR_WIDTH(8),
        .LOG2N(10)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .busy(busy),
        .done(done),
        .rom_en(rom_en),
        .rom_addr(rom_addr),
        .rom_twiddle(rom_twiddle),
        .tw_valid(tw_valid),
        .tw_ready(tw_ready),
        .tw_real(tw_real),
        .tw_imag(tw_imag),
        .tw_stage(tw_stage),
        .tw_last(tw_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rom_word(input logic [8:0] a);
        logic [31:0] re;
        logic [31:0] im;
        re = 32'(a) * 32'd3 + 32'h1111_0000;
        im = 32'hCAFE_0000 ^ 32'(a);
        return {re, im};
    endfunction

    // ROM with one cycle of read latency.
    logic [63:0] rom_q = 64'd0;
    always @(posedge clk) if (rom_en) rom_q <= rom_word(rom_addr);
    assign rom_twiddle = rom_q;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at cyc=%0d", name, act, exp, cyc);
        end
    endtask

    // Compare process: every cycle, outputs against the sequence model.
    initial begin : compare
        int  iss_idx;
        int  x_idx;
        int  lowrun;
        bit  prev_hs_last;
        bit  have_prev;
        bit  hs;
        logic [31:0] sv_re;
        logic [31:0] sv_im;
        logic [3:0]  sv_st;
        logic        sv_last;
        logic [63:0] w;
        iss_idx = 0; x_idx = 0; lowrun = 0; prev_hs_last = 0; have_prev = 0;
        sv_re = 0; sv_im = 0; sv_st = 0; sv_last = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                iss_idx = 0; x_idx = 0; lowrun = 0; prev_hs_last = 0; have_prev = 0;
            end else begin
                if (rom_en) begin
                    if (iss_idx >= N) begin
                        total++; bad++;
                        $display("FAIL issue_overrun actual=%0d reads required<=%0d", iss_idx + 1, N);
                    end else begin
                        check("rom_addr", 64'(rom_addr), 64'(exp_addr[iss_idx]));
                    end
                    iss_idx++;
                end
                if (!tw_ready) lowrun++; else lowrun = 0;
                if (lowrun >= 3) check("stall_rom_en", 64'(rom_en), 64'd0);
                if (have_prev && tw_valid) begin
                    check("stall_real", 64'(tw_real), 64'(sv_re));
                    check("stall_imag", 64'(tw_imag), 64'(sv_im));
                    check("stall_stage", 64'(tw_stage), 64'(sv_st));
                    check("stall_last", 64'(tw_last), 64'(sv_last));
                end
                have_prev = tw_valid && !tw_ready;
                sv_re = tw_real; sv_im = tw_imag; sv_st = tw_stage; sv_last = tw_last;
                hs = tw_valid && tw_ready;
                if (hs) begin
                    if (x_idx >= N) begin
                        total++; bad++;
                        $display("FAIL xfer_overrun actual=%0d transfers required<=%0d", x_idx + 1, N);
                    end else begin
                        w = rom_word(exp_addr[x_idx]);
                        check("tw_real", 64'(tw_real), 64'(w[63:32]));
                        check("tw_imag", 64'(tw_imag), 64'(w[31:0]));
                        check("tw_stage", 64'(tw_stage), 64'(exp_stage[x_idx]));
                        check("tw_last", 64'(tw_last), 64'(exp_last[x_idx]));
                    end
                    x_idx++;
                end
                check("credit_le2", 64'((iss_idx - x_idx) <= 2), 64'd1);
                check("done_timing", 64'(done), 64'(prev_hs_last));
                prev_hs_last = hs && (x_idx == N);
                if (done) begin
                    done_xfers = x_idx;
                    iss_idx = 0;
                    x_idx = 0;
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_rom_en"}, 64'(rom_en), 64'd0);
        check({tag, "_rom_addr"}, 64'(rom_addr), 64'd0);
        check({tag, "_tw_valid"}, 64'(tw_valid), 64'd0);
        check({tag, "_tw_real"}, 64'(tw_real), 64'd0);
        check({tag, "_tw_imag"}, 64'(tw_imag), 64'd0);
        check({tag, "_tw_stage"}, 64'(tw_stage), 64'd0);
        check({tag, "_tw_last"}, 64'(tw_last), 64'd0);
    endtask

    // mode 0: ready high, 1: 10-cycle stall in stage 3, 2: random ready,
    // 3: ready high with a stray start at cycle 100.
    task automatic run_seq(input int mode, input bit pre_started, input bit chain, input int rst_at);
        int k;
        int t0;
        int fv;
        int done_k;
        bit got;
        if (!pre_started) begin
            @(posedge clk); #1;
            start = 1'b1;
        end
        @(posedge clk); #1;
        start = 1'b0;
        t0 = cyc;
        check("c1_busy", 64'(busy), 64'd1);
        check("c1_rom_en", 64'(rom_en), 64'd1);
        check("c1_rom_addr", 64'(rom_addr), 64'd0);
        k = 1; fv = 0; done_k = 0; got = 0;
        while (!got && k <= 20000) begin
            if (done) begin
                got = 1;
                done_k = k;
                if (chain) start = 1'b1;
            end else begin
                if (rst_at != 0 && k == rst_at) begin
                    check("pre_rst_rom_en", 64'(rom_en), 64'd1);
                    rst = 1'b1;
                    #1;
                    check_reset_outputs("midrst");
                    @(posedge clk); @(posedge clk); #1;
                    rst = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        @(posedge clk); #1;
                        check("post_rst_done", 64'(done), 64'd0);
                        check("post_rst_busy", 64'(busy), 64'd0);
                    end
                    return;
                end
                case (mode)
                    1:       tw_ready = !(k >= 1800 && k < 1810);
                    2:       tw_ready = 1'($urandom_range(0, 1));
                    default: tw_ready = 1'b1;
                endcase
                start = (mode == 3 && k == 100);
                if (fv == 0 && tw_valid) fv = k;
                @(posedge clk); #1;
                k = cyc - t0 + 1;
            end
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL run_timeout actual=no done required=done within 20000 cycles");
        end
        check("first_valid_cycle", 64'(fv), 64'd3);
        if (mode == 0 || mode == 3) check("done_cycle", 64'(done_k), 64'd5123);
        if (mode == 1) check("done_cycle_stall", 64'(done_k), 64'd5133);
        @(negedge clk); #1;
        check("xfer_count", 64'(done_xfers), 64'(N));
        if (!chain) begin
            @(posedge clk); #1;
            start = 1'b0;
            check("busy_after_done", 64'(busy), 64'd0);
            check("done_after_pulse", 64'(done), 64'd0);
        end
    endtask

    initial begin : stim
        int s;
        int j;
        rst = 1'b1;
        start = 1'b0;
        tw_ready = 1'b1;
        // Sequence model: stage s, butterfly j, address (j * 2^s) mod 512.
        for (int idx = 0; idx < N; idx++) begin
            s = idx / 512;
            j = idx % 512;
            exp_addr[idx]  = 9'((j * (1 << s)) % 512);
            exp_stage[idx] = s;
            exp_last[idx]  = (idx == N - 1);
        end
        check("model_s1_j1", 64'(exp_addr[513]), 64'd2);
        check("model_s1_j256", 64'(exp_addr[768]), 64'd0);
        check("model_s3_j3", 64'(exp_addr[1539]), 64'd24);
        check("model_s9_j5", 64'(exp_addr[4613]), 64'd0);
        check("model_s0_j511", 64'(exp_addr[511]), 64'd511);
        check("model_stage_last", 64'(exp_stage[N-1]), 64'd9);
        check("model_last_flag", 64'(exp_last[N-1]), 64'd1);
        check("model_not_last", 64'(exp_last[N-2]), 64'd0);

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("rst");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("idle");

        run_seq(0, 1'b0, 1'b0, 0);   // full run, ready high
        run_seq(1, 1'b0, 1'b0, 0);   // stall mid stage 3
        run_seq(2, 1'b0, 1'b0, 0);   // random ready
        run_seq(3, 1'b0, 1'b0, 0);   // stray start during RUN
        run_seq(0, 1'b0, 1'b0, 2000);// reset mid-sequence
        run_seq(0, 1'b0, 1'b0, 0);   // clean run after reset
        run_seq(0, 1'b0, 1'b1, 0);   // first of back-to-back pair
        run_seq(0, 1'b1, 1'b0, 0);   // second, started in the done cycle

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
